delta_sigma_decimator: RTL and testbench

Receive-side counterpart of the first-order delta-sigma DAC. Takes a 1-bit oversampled bitstream (DAC output or external modulator) and reconstructs signed BW-bit samples using a 3rd-order CIC (sinc3) decimation filter.
Output scaling matches the DAC input format exactly. A DAC→decimator loopback returns the DAC's input code once the filter has settled.

---
 rtl/dsm_pkg.sv | 27 ++
 rtl/cic_comb_stage.sv | 24 ++
 rtl/delta_sigma_decimator.sv | 78 +++++++
 tb/tb_delta_sigma_decimator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma decimator family: CIC geometry and
// the output formatter that maps a sinc3 result onto the DAC code range.
package dsm_pkg;

    localparam int CIC_ORDER = 3;

    function automatic int cic_width(input int log2r);
        return CIC_ORDER * log2r + 1;
    endfunction

    // c3 spans [0, 2^(3*log2r)]; centre it, clip the single all-ones overflow
    // code, then keep the top bw bits (floor truncation).
    function automatic logic signed [31:0] cic_format(input logic [31:0] c3,
                                                      input int log2r,
                                                      input int bw);
        longint half;
        longint v;
        half = longint'(1) <<< (CIC_ORDER * log2r - 1);
        v    = longint'({32'd0, c3}) - half;
        if (v > half - 1) begin
            v = half - 1;
        end
        v = v >>> (CIC_ORDER * log2r - bw);
        return 32'(v);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: registers x - x_prev and advances its delay when enabled.
module cic_comb_stage #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] x_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            x_prev <= '0;
        end else if (en) begin
            y      <= x - x_prev;
            x_prev <= x;
        end
    end

endmodule

// File: rtl/delta_sigma_decimator.sv
// Sinc3 CIC decimator turning a 1-bit delta-sigma stream back into signed
// BW-bit samples scaled identically to the companion DAC's input code.
module delta_sigma_decimator
    import dsm_pkg::*;
#(
    parameter int BW    = 16,
    parameter int LOG2R = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          ds_i,
    output logic [BW-1:0] dout_o,
    output logic          valid_o
);

    localparam int W = cic_width(LOG2R);

    logic [W-1:0]     i1, i2, i3;
    logic [W-1:0]     c0, c1, c2, c3;
    logic [LOG2R-1:0] cnt;
    logic [3:0]       stage;
    logic [1:0]       warm;
    logic             tick;
    logic signed [31:0] fmt_full;

    assign tick     = ce_i && (cnt == {LOG2R{1'b1}});
    assign fmt_full = cic_format(32'(c3), LOG2R, BW);

    // stage[k] marks the clock k+1 cycles after a tick; wrap in the
    // integrators is cancelled exactly by the combs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i1      <= '0;
            i2      <= '0;
            i3      <= '0;
            c0      <= '0;
            cnt     <= '0;
            stage   <= '0;
            warm    <= '0;
            dout_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            if (ce_i) begin
                i1  <= i1 + W'(ds_i);
                i2  <= i2 + i1;
                i3  <= i3 + i2;
                cnt <= cnt + LOG2R'(1);
            end
            if (tick) begin
                c0 <= i3;
            end
            stage   <= {stage[2:0], tick};
            valid_o <= 1'b0;
            if (stage[3]) begin
                if (warm == 2'd3) begin
                    dout_o  <= BW'(fmt_full);
                    valid_o <= 1'b1;
                end else begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

    cic_comb_stage #(.W(W)) u_comb1 (
        .clk (clk_i), .rst (rst_i), .en (stage[0]), .x (c0), .y (c1)
    );

    cic_comb_stage #(.W(W)) u_comb2 (
        .clk (clk_i), .rst (rst_i), .en (stage[1]), .x (c1), .y (c2)
    );

    cic_comb_stage #(.W(W)) u_comb3 (
        .clk (clk_i), .rst (rst_i), .en (stage[2]), .x (c2), .y (c3)
    );

endmodule

// File: tb/tb_delta_sigma_decimator.sv
// Bench for delta_sigma_decimator: sinc3 FIR reference model over the sampled
// bitstream, checked every cycle, plus literal expectations for known densities.
module tb_delta_sigma_decimator;

    localparam int BW    = 16;
    localparam int LOG2R = 6;
    localparam int R     = 1 << LOG2R;

    localparam int M_ONES = 0, M_ZEROS = 1, M_ALT = 2, M_1110 = 3,
                   M_RAND = 4, M_DAC = 5, M_DAC_RAND = 6;
    localparam int CE_ON = 0, CE_TOG = 1, CE_RAND = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ce_i;
    logic          ds_i;
    logic [BW-1:0] dout_o;
    logic          valid_o;

    delta_sigma_decimator #(.BW(BW), .LOG2R(LOG2R)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ce_i    (ce_i),
        .ds_i    (ds_i),
        .dout_o  (dout_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int at;
        int val;
    } exp_t;

    int   h [4*R];
    bit   xq [$];
    exp_t expq [$];
    int   edge_count     = 0;
    int   rst_edge       = 0;
    int   last_tick_edge = -1;
    int   nce            = 0;
    int   ntick          = 0;
    logic exp_valid      = 1'b0;
    int   held           = 0;

    function automatic int g(input int m);
        return (m < 0) ? 0 : (m * (m - 1)) / 2;
    endfunction

    function automatic int model_fmt(input int y);
        int half;
        int v;
        half = 1 << (3*LOG2R - 1);
        v = y - half;
        if (v > half - 1) v = half - 1;
        return v >>> (3*LOG2R - BW);
    endfunction

    // Third difference (lag R) of the triple-summation kernel = sinc3 impulse response.
    task automatic build_kernel();
        for (int d = 0; d < 4*R; d++)
            h[d] = g(d) - 3*g(d - R) + 3*g(d - 2*R) - g(d - 3*R);
    endtask

    function automatic int sinc3_now();
        int y;
        int sz;
        y  = 0;
        sz = xq.size();
        for (int d = 0; d < 3*R && d < sz; d++)
            y += h[d] * int'(xq[sz-1-d]);
        return y;
    endfunction

    always @(posedge clk_i) begin
        edge_count++;
        exp_valid = 1'b0;
        if (rst_i) begin
            xq.delete();
            expq.delete();
            nce      = 0;
            ntick    = 0;
            held     = 0;
            rst_edge = edge_count;
        end else begin
            if (ce_i) begin
                if (nce % R == R - 1) begin
                    if (ntick >= 3)
                        expq.push_back('{at: edge_count + 4, val: model_fmt(sinc3_now())});
                    ntick++;
                    last_tick_edge = edge_count;
                end
                xq.push_back(ds_i);
                if (xq.size() > 4*R) void'(xq.pop_front());
                nce++;
            end
            if (expq.size() > 0 && expq[0].at == edge_count) begin
                exp_valid = 1'b1;
                held      = expq[0].val;
                void'(expq.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare and observation ----------------
    int first_rel       = -1;
    int prev_valid_edge = -1;
    int last_spacing    = -1;
    int last_dout       = 0;
    int nvalid          = 0;

    always @(negedge clk_i) begin
        check("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
        check("dout_o", $signed(dout_o), held);
        if (valid_o === 1'b1) begin
            if (first_rel < 0) first_rel = edge_count - rst_edge;
            if (prev_valid_edge >= 0) last_spacing = edge_count - prev_valid_edge;
            prev_valid_edge = edge_count;
            last_dout       = $signed(dout_o);
            nvalid++;
        end
    end

    // ---------------- stimulus ----------------
    int          pat      = 0;
    logic [15:0] dac_acc  = '0;
    logic [15:0] dac_code = '0;

    task automatic clear_obs();
        first_rel       = -1;
        prev_valid_edge = -1;
        last_spacing    = -1;
        nvalid          = 0;
        pat             = 0;
        dac_acc         = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ce_i  = 1'b1;
        ds_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_valid", {31'd0, valid_o}, 0);
        check("rst_dout", $signed(dout_o), 0);
        clear_obs();
    endtask

    task automatic drive(input int mode, input int ce_mode, input int cyc);
        logic        ce;
        logic        b;
        logic [16:0] sum;
        case (ce_mode)
            CE_TOG:  ce = (cyc % 2 == 0);
            CE_RAND: ce = ($urandom_range(0, 3) != 0);
            default: ce = 1'b1;
        endcase
        if (mode == M_DAC_RAND && cyc % 500 == 0) dac_code = 16'($urandom);
        case (mode)
            M_ONES:  b = 1'b1;
            M_ZEROS: b = 1'b0;
            M_ALT:   b = (pat % 2 == 0);
            M_1110:  b = (pat % 4 != 3);
            M_RAND:  b = 1'($urandom);
            default: begin
                sum = {1'b0, dac_acc} + {1'b0, dac_code ^ 16'h8000};
                b   = sum[16];
                if (ce) dac_acc = sum[15:0];
            end
        endcase
        if (ce) pat++;
        rst_i = 1'b0;
        ce_i  = ce;
        ds_i  = b;
    endtask

    task automatic run(input int n, input int mode, input int ce_mode);
        for (int i = 0; i < n; i++) begin
            drive(mode, ce_mode, i);
            @(negedge clk_i);
        end
    endtask

    initial begin
        bit found;
        build_kernel();
        rst_i = 1'b1;
        ce_i  = 1'b1;
        ds_i  = 1'b1;
        @(negedge clk_i);

        do_reset();
        run(4*R + 4 + 3*R + 8, M_ONES, CE_ON);
        check("ones_first_valid", first_rel, 4*R + 4);
        check("ones_value", last_dout, 32767);
        check("ones_spacing", last_spacing, R);

        do_reset();
        run(4*R + 4 + 2*R + 8, M_ZEROS, CE_ON);
        check("zeros_value", last_dout, -32768);

        do_reset();
        run(4*R + 4 + 2*R + 8, M_ALT, CE_ON);
        check("alt_value", last_dout, 0);

        do_reset();
        run(4*R + 4 + 2*R + 8, M_1110, CE_ON);
        check("p075_value", last_dout, 16384);

        do_reset();
        dac_code = 16'd16384;
        run(4*R + 4 + 3*R + 8, M_DAC, CE_ON);
        check("dac_loop_value", last_dout, 16384);

        do_reset();
        run(8*R + 4 + 4*R + 8, M_ONES, CE_TOG);
        check("ce_tog_first_valid", first_rel, 8*R + 3);
        check("ce_tog_spacing", last_spacing, 2*R);
        check("ce_tog_value", last_dout, 32767);

        // reset one cycle after a tick while the comb pipeline is busy
        do_reset();
        run(4*R + 4 + R, M_ONES, CE_ON);
        check("midrst_prior_valid", {31'd0, nvalid > 0}, 1);
        found = 1'b0;
        for (int i = 0; i < 4*R && !found; i++) begin
            drive(M_ONES, CE_ON, i);
            @(negedge clk_i);
            if (last_tick_edge == edge_count) found = 1'b1;
        end
        check("midrst_tick_found", {31'd0, found}, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_valid", {31'd0, valid_o}, 0);
        check("midrst_dout", $signed(dout_o), 0);
        clear_obs();
        run(4*R + 4 + R + 8, M_ONES, CE_ON);
        check("midrst_first_valid", first_rel, 4*R + 4);

        do_reset();
        run(3000, M_RAND, CE_RAND);
        check("rand_valids_seen", {31'd0, nvalid > 20}, 1);

        do_reset();
        run(3000, M_DAC_RAND, CE_RAND);
        check("dac_rand_valids_seen", {31'd0, nvalid > 20}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
